md5_step_scheduler: RTL and testbench

MD5_STEP_SCHEDULER -- requirements
Module: md5_step_scheduler

---
 rtl/md5_pkg.sv | 63 ++++++
 rtl/md5_k_rom.sv | 14 +
 rtl/md5_step_scheduler.sv | 160 ++++++++++++++++
 tb/tb_md5_step_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared encodings and constant tables for the MD5 step scheduler.
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } md5_state_e;

  // Round index constants, equal to step[5:4]
  localparam logic [1:0] ROUND_F = 2'd0;
  localparam logic [1:0] ROUND_G = 2'd1;
  localparam logic [1:0] ROUND_H = 2'd2;
  localparam logic [1:0] ROUND_I = 2'd3;

  localparam logic [5:0] STEP_FIRST = 6'd0;
  localparam logic [5:0] STEP_LAST  = 6'd63;

  // Left-rotate amounts, indexed [round][step[1:0]]
  localparam logic [4:0] MD5_S [0:3][0:3] = '{
    '{5'd7, 5'd12, 5'd17, 5'd22},
    '{5'd5, 5'd9,  5'd14, 5'd20},
    '{5'd4, 5'd11, 5'd16, 5'd23},
    '{5'd6, 5'd10, 5'd15, 5'd21}
  };

  // K[i] = floor(abs(sin(i+1)) * 2^32)
  localparam logic [31:0] MD5_K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Message word index for a step; only i mod 16 matters, so 4-bit
  // shift/add arithmetic gives the mod-16 result directly.
  function automatic logic [3:0] md5_g_idx(input logic [5:0] step);
    logic [3:0] w_i;
    w_i = step[3:0];
    case (step[5:4])
      ROUND_F: md5_g_idx = w_i;
      ROUND_G: md5_g_idx = (w_i << 3'd2) + w_i + 4'd1;
      ROUND_H: md5_g_idx = (w_i << 3'd1) + w_i + 4'd5;
      ROUND_I: md5_g_idx = (w_i << 3'd3) - w_i;
      default: md5_g_idx = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/md5_k_rom.sv
// Combinational 64-entry ROM of the MD5 additive constants.
module md5_k_rom
  import md5_pkg::*;
(
  input  logic [5:0]  i_addr,
  output logic [31:0] o_k
);

  // Table lookup addressed by the current step
  always_comb begin
    o_k = MD5_K[i_addr];
  end

endmodule

// File: rtl/md5_step_scheduler.sv
// Control sequencer for one 64-step MD5 compression: drives step index,
// round function, message index, rotate amount and K constant to a datapath.
// All outputs are decoded from registered state; hold is registered before
// use so no input reaches an output combinationally. A hold seen in cycle n
// therefore freezes the step presented in cycle n+1.
module md5_step_scheduler
  import md5_pkg::*;
#(
  parameter logic HOLD_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_hold,
  output logic        o_busy,
  output logic        o_load_iv,
  output logic        o_step_en,
  output logic [5:0]  o_step,
  output logic [1:0]  o_func_sel,
  output logic [3:0]  o_g_idx,
  output logic [4:0]  o_s_amt,
  output logic [31:0] o_k_const,
  output logic        o_final_add,
  output logic        o_done
);

  md5_state_e  r_state;
  md5_state_e  w_state_nxt;
  logic [5:0]  r_step;
  logic [5:0]  w_step_nxt;
  logic        r_hold;
  logic        w_hold_nxt;
  logic        w_advance;
  logic [31:0] w_k;

  md5_k_rom u_k_rom (
    .i_addr (r_step),
    .o_k    (w_k)
  );

  // Capture a stall request only while running; ignored in every other state
  always_comb begin
    w_hold_nxt = 1'b0;
    if ((HOLD_EN == 1'b1) && (r_state == ST_RUN)) begin
      w_hold_nxt = i_hold;
    end else begin
      w_hold_nxt = 1'b0;
    end
  end

  assign w_advance = (r_state == ST_RUN) && !r_hold;

  // Next-state and step counter; counter leaves 63 only through the RUN exit
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      ST_IDLE: begin
        w_step_nxt = STEP_FIRST;
        if (i_start && !i_abort) begin
          w_state_nxt = ST_INIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INIT: begin
        w_step_nxt = STEP_FIRST;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = STEP_FIRST;
        end else if (!w_advance) begin
          w_state_nxt = ST_RUN;
          w_step_nxt  = r_step;
        end else if (r_step == STEP_LAST) begin
          w_state_nxt = ST_FINAL;
          w_step_nxt  = STEP_FIRST;
        end else begin
          w_state_nxt = ST_RUN;
          w_step_nxt  = r_step + 6'd1;
        end
      end
      ST_FINAL: begin
        w_step_nxt = STEP_FIRST;
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_step_nxt  = STEP_FIRST;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_step_nxt  = STEP_FIRST;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and hold registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_FIRST;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Moore output decode from state, counter and registered hold
  always_comb begin
    o_busy      = 1'b0;
    o_load_iv   = 1'b0;
    o_step_en   = 1'b0;
    o_final_add = 1'b0;
    o_done      = 1'b0;
    o_step      = r_step;
    o_func_sel  = r_step[5:4];
    o_g_idx     = md5_g_idx(r_step);
    o_s_amt     = MD5_S[r_step[5:4]][r_step[1:0]];
    o_k_const   = w_k;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
      end
      ST_INIT: begin
        o_busy    = 1'b1;
        o_load_iv = 1'b1;
      end
      ST_RUN: begin
        o_busy    = 1'b1;
        o_step_en = w_advance;
      end
      ST_FINAL: begin
        o_busy      = 1'b1;
        o_final_add = 1'b1;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_md5_step_scheduler.sv
// Testbench for md5_step_scheduler.
module tb_md5_step_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        hold;
  logic        o_busy;
  logic        o_load_iv;
  logic        o_step_en;
  logic [5:0]  o_step;
  logic [1:0]  o_func_sel;
  logic [3:0]  o_g_idx;
  logic [4:0]  o_s_amt;
  logic [31:0] o_k_const;
  logic        o_final_add;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  step;
    logic [1:0]  fs;
    logic [3:0]  g;
    logic [4:0]  s;
    logic [31:0] k;
  } vec_t;

  vec_t vt [10];
  int   step_q [$];
  int   done_q [$];

  md5_step_scheduler #(.HOLD_EN(1'b1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_hold      (hold),
    .o_busy      (o_busy),
    .o_load_iv   (o_load_iv),
    .o_step_en   (o_step_en),
    .o_step      (o_step),
    .o_func_sel  (o_func_sel),
    .o_g_idx     (o_g_idx),
    .o_s_amt     (o_s_amt),
    .o_k_const   (o_k_const),
    .o_final_add (o_final_add),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_load_iv"}, {31'd0, o_load_iv}, 32'd0);
    chk({tag, "_step_en"}, {31'd0, o_step_en}, 32'd0);
    chk({tag, "_step"}, {26'd0, o_step}, 32'd0);
    chk({tag, "_final_add"}, {31'd0, o_final_add}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_k"}, o_k_const, 32'hd76aa478);
    chk({tag, "_s"}, {27'd0, o_s_amt}, 32'd7);
  endtask

  // One operation: start at cycle 0, optional hold window, abort, reset and
  // repeated starts; expected steps and done cycle queued up front.
  task automatic do_run(input int hold_cyc, input int hold_len, input int hold_step,
                        input int abort_cyc, input int rst_cyc, input int dup_a,
                        input int dup_b, input int exp_done, input int exp_steps);
    int ndone;
    int end_cyc;
    int front;
    ndone   = 0;
    end_cyc = (abort_cyc >= 0) ? abort_cyc : rst_cyc;
    step_q.delete();
    done_q.delete();
    for (int i = 0; i < exp_steps; i++) step_q.push_back(i);
    if (exp_done >= 0) done_q.push_back(exp_done);
    for (int c = 0; c < 76; c++) begin
      start = ((c == 0) || (c == dup_a) || (c == dup_b)) ? 1'b1 : 1'b0;
      hold  = ((hold_len > 0) && (c >= hold_cyc) && (c < hold_cyc + hold_len)) ? 1'b1 : 1'b0;
      abort = (c == abort_cyc) ? 1'b1 : 1'b0;
      rst_n = (c == rst_cyc) ? 1'b0 : 1'b1;
      if (o_step_en) begin
        if (step_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_step_en: step_en at cycle %0d step %0d, none expected", c, o_step);
        end else begin
          front = step_q.pop_front();
          chk("step_seq", {26'd0, o_step}, front);
        end
        foreach (vt[j]) begin
          if (vt[j].step == o_step) begin
            chk("vec_func_sel", {30'd0, o_func_sel}, {30'd0, vt[j].fs});
            chk("vec_g_idx", {28'd0, o_g_idx}, {28'd0, vt[j].g});
            chk("vec_s_amt", {27'd0, o_s_amt}, {27'd0, vt[j].s});
            chk("vec_k_const", o_k_const, vt[j].k);
          end
        end
      end
      if (o_load_iv) begin
        chk("load_iv_cycle", c, 32'd1);
        chk("init_step", {26'd0, o_step}, 32'd0);
        chk("init_k", o_k_const, 32'hd76aa478);
        chk("init_g_idx", {28'd0, o_g_idx}, 32'd0);
      end
      if (o_final_add) chk("final_add_cycle", c, exp_done - 1);
      if (o_done) begin
        ndone++;
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done at cycle %0d, none expected", c);
        end else begin
          front = done_q.pop_front();
          chk("done_cycle", c, front);
        end
      end
      if ((hold_len > 0) && (c > hold_cyc) && (c <= hold_cyc + hold_len)) begin
        chk("hold_step", {26'd0, o_step}, hold_step);
        chk("hold_step_en", {31'd0, o_step_en}, 32'd0);
      end
      if ((exp_done >= 0) && (c == exp_done)) chk("busy_in_done", {31'd0, o_busy}, 32'd1);
      if ((exp_done >= 0) && (c == exp_done + 1)) chk("busy_after_done", {31'd0, o_busy}, 32'd0);
      if ((end_cyc >= 0) && (c == end_cyc + 1)) chk_idle("after_cancel");
      tick();
    end
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    chk("steps_left", step_q.size(), 32'd0);
    chk("done_count", ndone, (exp_done >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    vt[0] = '{6'd0,  2'd0, 4'd0,  5'd7,  32'hd76aa478};
    vt[1] = '{6'd1,  2'd0, 4'd1,  5'd12, 32'he8c7b756};
    vt[2] = '{6'd16, 2'd1, 4'd1,  5'd5,  32'hf61e2562};
    vt[3] = '{6'd17, 2'd1, 4'd6,  5'd9,  32'hc040b340};
    vt[4] = '{6'd23, 2'd1, 4'd4,  5'd20, 32'he7d3fbc8};
    vt[5] = '{6'd32, 2'd2, 4'd5,  5'd4,  32'hfffa3942};
    vt[6] = '{6'd33, 2'd2, 4'd8,  5'd11, 32'h8771f681};
    vt[7] = '{6'd45, 2'd2, 4'd12, 5'd11, 32'he6db99e5};
    vt[8] = '{6'd50, 2'd3, 4'd14, 5'd15, 32'hab9423a7};
    vt[9] = '{6'd63, 2'd3, 4'd9,  5'd21, 32'heb86d391};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hold  = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    chk_idle("reset");
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    // Plain run: done at 67
    do_run(-1, 0, 0, -1, -1, -1, -1, 67, 64);
    // Hold raised during step 19 freezes step 20 for three cycles: done at 70
    do_run(21, 3, 20, -1, -1, -1, -1, 70, 64);
    // Abort during step 40 (cycle 42): steps 0..40 only, no final/done
    do_run(-1, 0, 0, 42, -1, -1, -1, -1, 41);
    do_run(-1, 0, 0, -1, -1, -1, -1, 67, 64);
    // Repeated start at step 10 (cycle 12) and in FINAL (cycle 66)
    do_run(-1, 0, 0, -1, -1, 12, 66, 67, 64);
    // Reset during step 30 (cycle 32)
    do_run(-1, 0, 0, -1, 32, -1, -1, -1, 31);

    // Start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", {31'd0, o_busy}, 32'd0);
    chk("start_abort_load_iv", {31'd0, o_load_iv}, 32'd0);
    tick();
    chk("start_abort_busy2", {31'd0, o_busy}, 32'd0);

    do_run(-1, 0, 0, -1, -1, -1, -1, 67, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
